pendulum_encoder: RTL and testbench
===================================

PENDULUM_ENCODER -- requirements
Module: pendulum_encoder

Interface
REQ-001 SHALL provide parameter POS_CENTER, default 512: the Position value loaded at reset, on index and on re-centre.
REQ-002 SHALL provide parameter FILT_CYCLES, default 4, range 1..15: number of stable samples the glitch filter requires.
REQ-003 SHALL have ports, in this order:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enc_a  input  1  quadrature channel A, asynchronous to clk.
- enc_b  input  1  quadrature channel B, asynchronous to clk.
- enc_z  input  1  index pulse, asynchronous to clk.
- zero_req  input  1  synchronous re-centre request.
- Position  output  10  unsigned pendulum position; POS_CENTER means upright/zero.
- Direction  output  1  1 = last count increased, 0 = decreased.
- pos_valid  output  1  one-cycle strobe when Position changes.
- quad_err  output  1  one-cycle strobe on an illegal A/B transition.

Function
REQ-004 SHALL pass enc_a, enc_b and enc_z through a 2-flop synchroniser each.
REQ-005 SHALL decode synchronised {A,B} with Gray sequence 00->01->11->10->00 = +1 per step; the reverse sequence = -1.
REQ-006 SHALL, when A and B change in the same sample, leave Position unchanged, pulse quad_err for 1 cycle, and adopt the new {A,B} as the reference state.
REQ-007 SHALL update Position and Direction in the cycle after the decoded step, giving a fixed latency of 3 clk from input edge to Position change when filtering is off.
REQ-008 SHALL saturate Position at 0 and 1023, with no wrap-around.
- A step beyond a limit leaves Position unchanged, gives no pos_valid, and still updates Direction.
REQ-009 SHALL load Position = POS_CENTER on a synchronised enc_z rising edge, or on zero_req = 1.
REQ-010 SHALL apply priority zero_req > enc_z edge > quadrature count when events coincide in the same cycle.
- The count for that cycle is discarded.
- Direction is unchanged.
REQ-011 SHALL assert pos_valid for exactly 1 cycle whenever the registered Position value changes, and never otherwise.
- Re-centring while already at POS_CENTER gives no pos_valid.
REQ-012 SHALL use a 2-state FSM:
- INIT: first cycle after reset release; captures {A,B} as the reference, no counting.
- TRACK: steady-state counting; always entered from INIT after that one cycle.
REQ-013 SHALL hold Direction until the next valid step; index and re-centre events do not alter it.

Reset
REQ-014 SHALL, on reset = 0, immediately drive:
- Position = POS_CENTER, Direction = 0, pos_valid = 0, quad_err = 0.
- FSM = INIT; synchronisers and filter counters cleared.
REQ-015 SHALL discard any partial filter or count state on reset asserted mid-operation.
- No pos_valid is generated by reset itself.

Configuration
REQ-016 SHALL compile the glitch filter only when macro PENDULUM_ENC_FILTER_EN is defined, with this behaviour:
- With the macro: each synchronised channel is accepted only after FILT_CYCLES consecutive identical samples, and latency becomes 3 + FILT_CYCLES clk.
- Without the macro: synchronised signals feed the decoder directly; latency is 3 clk and FILT_CYCLES is ignored.

Structure
REQ-017 SHALL take the following from shared package pendulum_pkg:
- POS_WIDTH = 10, POS_MAX = 1023, POS_CENTER_DEFAULT = 512.
- FSM state typedef {INIT, TRACK}.
- The 2-bit mode encoding (Braking, Short, Open, Driving) already used by the pendulum controller.
REQ-018 SHALL implement synchroniser-plus-filter per channel as one sub-module, enc_sync_filter, instantiated three times.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- Reset release, then 4 forward Gray steps spaced 10 clk -> Position 512->516; 4 pos_valid pulses; Direction = 1; each change 3 clk after its edge (filter off).
- From Position 1021, 5 forward steps -> Position 1022, 1023, then holds 1023; exactly 2 pos_valid pulses.
- From Position 2, 4 reverse steps -> Position 0 and holds; Direction = 0.
- {A,B} 00->11 in one step -> quad_err pulse 1 cycle; Position unchanged; next 11->10 counts +1.
- zero_req, enc_z rise and a forward step in the same cycle from Position 600 -> Position 512; one pos_valid; Direction unchanged.
- With PENDULUM_ENC_FILTER_EN and FILT_CYCLES = 4: a 2-cycle glitch on A -> no count; a clean step -> Position changes 7 clk after the edge.

Source files
------------

// File: rtl/pendulum_pkg.sv
// ---------------------------------------------------------------------------
// pendulum_pkg
// Shared definitions for the pendulum controller and its position encoder.
//   POS_WIDTH / POS_MAX / POS_CENTER_DEFAULT : position register geometry
//   enc_state_e  : encoder tracking FSM states (INIT, TRACK)
//   motor_mode_e : 2-bit H-bridge mode encoding used by the controller
//   step_e       : result of one quadrature decode
//   gray_step()  : classifies a {A,B} transition as none / +1 / -1 / illegal
// ---------------------------------------------------------------------------
package pendulum_pkg;

    localparam int unsigned POS_WIDTH          = 10;
    localparam int unsigned POS_MAX            = 1023;
    localparam int unsigned POS_CENTER_DEFAULT = 512;

    typedef enum logic {
        INIT,
        TRACK
    } enc_state_e;

    typedef enum logic [1:0] {
        Braking = 2'b00,
        Short   = 2'b01,
        Open    = 2'b10,
        Driving = 2'b11
    } motor_mode_e;

    // Encoding chosen so that the modulo-4 phase difference casts directly.
    typedef enum logic [1:0] {
        StepNone = 2'd0,
        StepInc  = 2'd1,
        StepErr  = 2'd2,
        StepDec  = 2'd3
    } step_e;

    // {A,B} Gray order 00,01,11,10 maps to phase {A, A^B} = 0,1,2,3.
    // Phase difference 1 is forward, 3 is reverse, 2 means both bits flipped.
    function automatic step_e gray_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        logic [1:0] prev_ph;
        logic [1:0] cur_ph;
        logic [1:0] diff;
        prev_ph = {prev_ab[1], prev_ab[1] ^ prev_ab[0]};
        cur_ph  = {cur_ab[1], cur_ab[1] ^ cur_ab[0]};
        diff    = cur_ph - prev_ph;
        return step_e'(diff);
    endfunction

endpackage

// File: rtl/enc_sync_filter.sv
// ---------------------------------------------------------------------------
// enc_sync_filter
// Two-flop synchroniser for one asynchronous encoder line, optionally
// followed by a glitch filter that only accepts a new level after
// FILT_CYCLES consecutive identical synchronised samples.
// Optional feature macro: PENDULUM_ENC_FILTER_EN (filter built only if defined).
// Ports:
//   clk   in  system clock, rising edge
//   reset in  asynchronous active-low reset; clears sync and filter state
//   din   in  raw asynchronous input
//   dout  out synchronised (and filtered, if enabled) level
// ---------------------------------------------------------------------------
module enc_sync_filter #(
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

`ifdef PENDULUM_ENC_FILTER_EN
    // The new level is adopted on the FILT_CYCLES-th differing sample, so the
    // filter adds exactly FILT_CYCLES cycles of latency.
    localparam logic [3:0] CntLast = 4'(FILT_CYCLES - 1);

    logic       filt_q;
    logic       filt_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = 4'd0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CntLast) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout = filt_q;
`else
    logic unused_filt_cfg;
    assign unused_filt_cfg = ^4'(FILT_CYCLES);

    assign dout = sync2_q;
`endif

endmodule

// File: rtl/pendulum_encoder.sv
// ---------------------------------------------------------------------------
// pendulum_encoder
// Quadrature decoder producing a saturating 10-bit pendulum position.
// Index pulse (enc_z rising) and zero_req re-centre the position.
// Optional feature macro: PENDULUM_ENC_FILTER_EN (per-channel glitch filter).
// Ports:
//   clk        in  system clock, rising edge
//   reset      in  asynchronous active-low reset
//   enc_a      in  quadrature channel A (async)
//   enc_b      in  quadrature channel B (async)
//   enc_z      in  index pulse (async)
//   zero_req   in  synchronous re-centre request
//   Position   out unsigned position, POS_CENTER = upright
//   Direction  out 1 = last step increased, 0 = decreased
//   pos_valid  out one-cycle strobe when Position changes
//   quad_err   out one-cycle strobe on an illegal A/B transition
// ---------------------------------------------------------------------------
module pendulum_encoder
    import pendulum_pkg::*;
#(
    parameter int unsigned POS_CENTER  = POS_CENTER_DEFAULT,
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enc_z,
    input  logic                 zero_req,
    output logic [POS_WIDTH-1:0] Position,
    output logic                 Direction,
    output logic                 pos_valid,
    output logic                 quad_err
);

    localparam logic [POS_WIDTH-1:0] PosCenter = POS_WIDTH'(POS_CENTER);
    localparam logic [POS_WIDTH-1:0] PosMax    = POS_WIDTH'(POS_MAX);
    localparam logic [POS_WIDTH-1:0] PosOne    = POS_WIDTH'(1);

    logic a_s;
    logic b_s;
    logic z_s;

    enc_sync_filter #(.FILT_CYCLES(FILT_CYCLES)) u_sync_a (
        .clk   (clk),
        .reset (reset),
        .din   (enc_a),
        .dout  (a_s)
    );

    enc_sync_filter #(.FILT_CYCLES(FILT_CYCLES)) u_sync_b (
        .clk   (clk),
        .reset (reset),
        .din   (enc_b),
        .dout  (b_s)
    );

    enc_sync_filter #(.FILT_CYCLES(FILT_CYCLES)) u_sync_z (
        .clk   (clk),
        .reset (reset),
        .din   (enc_z),
        .dout  (z_s)
    );

    enc_state_e           state_q, state_d;
    logic [1:0]           ab_ref_q, ab_ref_d;
    logic                 z_prev_q;
    logic [POS_WIDTH-1:0] pos_q, pos_d;
    logic                 dir_q, dir_d;
    logic                 valid_q;
    logic                 err_q, err_d;

    step_e step;
    logic  z_rise;

    assign step   = gray_step(ab_ref_q, {a_s, b_s});
    assign z_rise = z_s & ~z_prev_q;

    always_comb begin
        state_d  = state_q;
        ab_ref_d = {a_s, b_s};   // reference always follows the sample, also after errors
        pos_d    = pos_q;
        dir_d    = dir_q;
        err_d    = 1'b0;

        unique case (state_q)
            INIT:  state_d = TRACK;
            TRACK: err_d   = (step == StepErr);
            default: state_d = INIT;
        endcase

        // Re-centre wins over counting; Direction is left alone.
        if (zero_req || z_rise) begin
            pos_d = PosCenter;
        end else if (state_q == TRACK) begin
            case (step)
                StepInc: begin
                    dir_d = 1'b1;
                    if (pos_q != PosMax) pos_d = pos_q + PosOne;
                end
                StepDec: begin
                    dir_d = 1'b0;
                    if (pos_q != '0) pos_d = pos_q - PosOne;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= INIT;
            ab_ref_q <= 2'b00;
            z_prev_q <= 1'b0;
            pos_q    <= PosCenter;
            dir_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ab_ref_q <= ab_ref_d;
            z_prev_q <= z_s;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            valid_q  <= (pos_d != pos_q);
            err_q    <= err_d;
        end
    end

    assign Position  = pos_q;
    assign Direction = dir_q;
    assign pos_valid = valid_q;
    assign quad_err  = err_q;

endmodule

// File: tb/tb_pendulum_encoder.sv
`timescale 1ns/1ps
module tb_pendulum_encoder;

`ifdef PENDULUM_ENC_FILTER_EN
    localparam int Lat = 3 + 4;
`else
    localparam int Lat = 3;
`endif
    localparam int Gap = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       enc_a;
    logic       enc_b;
    logic       enc_z;
    logic       zero_req;
    logic [9:0] Position;
    logic       Direction;
    logic       pos_valid;
    logic       quad_err;

    int         total = 0;
    int         bad = 0;
    int         vcnt = 0;
    int         qcnt = 0;
    int         v0;
    int         q0;
    logic [1:0] ab_cur = 2'b00;

    pendulum_encoder #(
        .POS_CENTER  (512),
        .FILT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .enc_z     (enc_z),
        .zero_req  (zero_req),
        .Position  (Position),
        .Direction (Direction),
        .pos_valid (pos_valid),
        .quad_err  (quad_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pos_valid === 1'b1) vcnt <= vcnt + 1;
        if (quad_err === 1'b1) qcnt <= qcnt + 1;
    end

    function automatic logic [1:0] fwd_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic drive_ab(input logic [1:0] ab);
        @(posedge clk);
        #1;
        enc_a  = ab[1];
        enc_b  = ab[0];
        ab_cur = ab;
    endtask

    task automatic move(input int n, input bit fwd);
        for (int i = 0; i < n; i++) begin
            drive_ab(fwd ? fwd_of(ab_cur) : rev_of(ab_cur));
            repeat (Gap - 1) @(posedge clk);
        end
        repeat (Lat + 2) @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0; zero_req = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (Position !== 10'd512) begin bad++; $display("FAIL reset_pos: got %0d want 512", Position); end
        total++; if (Direction !== 1'b0) begin bad++; $display("FAIL reset_dir: got %b want 0", Direction); end
        total++; if (pos_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", pos_valid); end
        total++; if (quad_err !== 1'b0) begin bad++; $display("FAIL reset_qerr: got %b want 0", quad_err); end
        reset = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_forward();
        v0 = vcnt;
        for (int i = 1; i <= 4; i++) begin
            drive_ab(fwd_of(ab_cur));
            repeat (Lat - 1) @(posedge clk);
            @(negedge clk);
            total++; if (Position !== 10'(511 + i)) begin bad++; $display("FAIL fwd_early: got %0d want %0d", Position, 511 + i); end
            @(posedge clk);
            @(negedge clk);
            total++; if (Position !== 10'(512 + i)) begin bad++; $display("FAIL fwd_pos: got %0d want %0d", Position, 512 + i); end
            total++; if (pos_valid !== 1'b1) begin bad++; $display("FAIL fwd_valid: got %b want 1", pos_valid); end
            repeat (10 - Lat - 1) @(posedge clk);
        end
        repeat (3) @(negedge clk);
        total++; if (vcnt - v0 !== 4) begin bad++; $display("FAIL fwd_valid_cnt: got %0d want 4", vcnt - v0); end
        total++; if (Direction !== 1'b1) begin bad++; $display("FAIL fwd_dir: got %b want 1", Direction); end
    endtask

    task automatic test_sat_high();
        int exp_pos;
        move(505, 1'b1);
        @(negedge clk);
        total++; if (Position !== 10'd1021) begin bad++; $display("FAIL move_1021: got %0d want 1021", Position); end
        v0 = vcnt;
        for (int i = 1; i <= 5; i++) begin
            exp_pos = (1021 + i > 1023) ? 1023 : 1021 + i;
            drive_ab(fwd_of(ab_cur));
            repeat (Lat) @(posedge clk);
            @(negedge clk);
            total++; if (Position !== 10'(exp_pos)) begin bad++; $display("FAIL sat_hi_pos: got %0d want %0d", Position, exp_pos); end
            repeat (10 - Lat - 1) @(posedge clk);
        end
        repeat (3) @(negedge clk);
        total++; if (vcnt - v0 !== 2) begin bad++; $display("FAIL sat_hi_valid_cnt: got %0d want 2", vcnt - v0); end
        total++; if (Direction !== 1'b1) begin bad++; $display("FAIL sat_hi_dir: got %b want 1", Direction); end
    endtask

    task automatic test_sat_low();
        int exp_pos;
        move(1021, 1'b0);
        @(negedge clk);
        total++; if (Position !== 10'd2) begin bad++; $display("FAIL move_2: got %0d want 2", Position); end
        v0 = vcnt;
        for (int i = 1; i <= 4; i++) begin
            exp_pos = (2 - i < 0) ? 0 : 2 - i;
            drive_ab(rev_of(ab_cur));
            repeat (Lat) @(posedge clk);
            @(negedge clk);
            total++; if (Position !== 10'(exp_pos)) begin bad++; $display("FAIL sat_lo_pos: got %0d want %0d", Position, exp_pos); end
            repeat (10 - Lat - 1) @(posedge clk);
        end
        repeat (3) @(negedge clk);
        total++; if (vcnt - v0 !== 2) begin bad++; $display("FAIL sat_lo_valid_cnt: got %0d want 2", vcnt - v0); end
        total++; if (Direction !== 1'b0) begin bad++; $display("FAIL sat_lo_dir: got %b want 0", Direction); end
    endtask

    task automatic test_quad_err();
        while (ab_cur != 2'b00) move(1, 1'b0);
        v0 = vcnt;
        q0 = qcnt;
        drive_ab(2'b11);
        repeat (Lat - 1) @(posedge clk);
        @(negedge clk);
        total++; if (quad_err !== 1'b0) begin bad++; $display("FAIL qerr_early: got %b want 0", quad_err); end
        @(posedge clk);
        @(negedge clk);
        total++; if (quad_err !== 1'b1) begin bad++; $display("FAIL qerr_pulse: got %b want 1", quad_err); end
        @(posedge clk);
        @(negedge clk);
        total++; if (quad_err !== 1'b0) begin bad++; $display("FAIL qerr_width: got %b want 0", quad_err); end
        repeat (4) @(negedge clk);
        total++; if (Position !== 10'd0) begin bad++; $display("FAIL qerr_pos: got %0d want 0", Position); end
        total++; if (qcnt - q0 !== 1) begin bad++; $display("FAIL qerr_cnt: got %0d want 1", qcnt - q0); end
        total++; if (vcnt - v0 !== 0) begin bad++; $display("FAIL qerr_no_valid: got %0d want 0", vcnt - v0); end
        move(1, 1'b1);
        @(negedge clk);
        total++; if (Position !== 10'd1) begin bad++; $display("FAIL qerr_next_pos: got %0d want 1", Position); end
        total++; if (Direction !== 1'b1) begin bad++; $display("FAIL qerr_next_dir: got %b want 1", Direction); end
    endtask

    task automatic test_coincide();
        move(600, 1'b1);
        move(1, 1'b0);
        @(negedge clk);
        total++; if (Position !== 10'd600) begin bad++; $display("FAIL move_600: got %0d want 600", Position); end
        total++; if (Direction !== 1'b0) begin bad++; $display("FAIL pre_co_dir: got %b want 0", Direction); end
        v0 = vcnt;
        @(posedge clk);
        #1;
        ab_cur = fwd_of(ab_cur);
        enc_a  = ab_cur[1];
        enc_b  = ab_cur[0];
        enc_z  = 1'b1;
        repeat (Lat - 1) @(posedge clk);
        #1 zero_req = 1'b1;
        @(posedge clk);
        #1 zero_req = 1'b0;
        @(negedge clk);
        total++; if (Position !== 10'd512) begin bad++; $display("FAIL co_pos: got %0d want 512", Position); end
        total++; if (Direction !== 1'b0) begin bad++; $display("FAIL co_dir: got %b want 0", Direction); end
        repeat (10) @(negedge clk);
        total++; if (vcnt - v0 !== 1) begin bad++; $display("FAIL co_valid_cnt: got %0d want 1", vcnt - v0); end
        total++; if (Position !== 10'd512) begin bad++; $display("FAIL co_hold: got %0d want 512", Position); end
        // Re-centre while already centred: no strobe.
        v0 = vcnt;
        @(posedge clk);
        #1 zero_req = 1'b1;
        @(posedge clk);
        #1 zero_req = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (vcnt - v0 !== 0) begin bad++; $display("FAIL center_no_valid: got %0d want 0", vcnt - v0); end
        enc_z = 1'b0;
        repeat (Lat + 2) @(posedge clk);
        move(1, 1'b1);
        @(negedge clk);
        total++; if (Position !== 10'd513) begin bad++; $display("FAIL idx_pre: got %0d want 513", Position); end
        @(posedge clk);
        #1 enc_z = 1'b1;
        repeat (Lat + 2) @(negedge clk);
        total++; if (Position !== 10'd512) begin bad++; $display("FAIL idx_pos: got %0d want 512", Position); end
        total++; if (Direction !== 1'b1) begin bad++; $display("FAIL idx_dir: got %b want 1", Direction); end
        enc_z = 1'b0;
        repeat (Lat + 2) @(posedge clk);
    endtask

    task automatic test_mid_reset();
        move(1, 1'b1);
        while (ab_cur != 2'b10) move(1, 1'b1);
        drive_ab(2'b00);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        total++; if (Position !== 10'd512) begin bad++; $display("FAIL mid_rst_pos: got %0d want 512", Position); end
        total++; if (Direction !== 1'b0) begin bad++; $display("FAIL mid_rst_dir: got %b want 0", Direction); end
        total++; if (pos_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", pos_valid); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        v0 = vcnt;
        repeat (12) @(negedge clk);
        total++; if (Position !== 10'd512) begin bad++; $display("FAIL post_rst_pos: got %0d want 512", Position); end
        total++; if (vcnt - v0 !== 0) begin bad++; $display("FAIL post_rst_valid: got %0d want 0", vcnt - v0); end
        move(1, 1'b1);
        @(negedge clk);
        total++; if (Position !== 10'd513) begin bad++; $display("FAIL post_rst_count: got %0d want 513", Position); end
    endtask

`ifdef PENDULUM_ENC_FILTER_EN
    task automatic test_filter();
        v0 = vcnt;
        @(posedge clk);
        #1 enc_a = ~ab_cur[1];
        @(posedge clk);
        @(posedge clk);
        #1 enc_a = ab_cur[1];
        repeat (15) @(negedge clk);
        total++; if (Position !== 10'd513) begin bad++; $display("FAIL glitch_pos: got %0d want 513", Position); end
        total++; if (vcnt - v0 !== 0) begin bad++; $display("FAIL glitch_valid: got %0d want 0", vcnt - v0); end
        drive_ab(fwd_of(ab_cur));
        repeat (Lat - 1) @(posedge clk);
        @(negedge clk);
        total++; if (Position !== 10'd513) begin bad++; $display("FAIL filt_early: got %0d want 513", Position); end
        @(posedge clk);
        @(negedge clk);
        total++; if (Position !== 10'd514) begin bad++; $display("FAIL filt_pos: got %0d want 514", Position); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forward();
        test_sat_high();
        test_sat_low();
        test_quad_err();
        test_coincide();
        test_mid_reset();
`ifdef PENDULUM_ENC_FILTER_EN
        test_filter();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
